// File: rtl/trace_pkg.sv
// Shared types for the execution tracer: state encoding and trace entry layout.
package trace_pkg;

    localparam int IR_W      = 32;
    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0]  pc;
        logic [IR_W-1:0]      ir;
        logic [CNT_W_DEF-1:0] cycle;
    } entry_t;

    function automatic int entry_w(input int xlen, input int cnt_w);
        return xlen + IR_W + cnt_w;
    endfunction

endpackage

// File: rtl/trace_monitor_if.sv
// Retire stream into the tracer and valid/ready drain port out of it.
interface trace_monitor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             retire_valid;
    logic [XLEN-1:0]  retire_pc;
    logic [31:0]      retire_ir;

    logic             rd_valid;
    logic             rd_ready;
    logic [XLEN-1:0]  rd_pc;
    logic [31:0]      rd_ir;
    logic [CNT_W-1:0] rd_cycle;

    modport master (
        input  retire_valid, retire_pc, retire_ir, rd_ready,
        output rd_valid, rd_pc, rd_ir, rd_cycle
    );

    modport slave (
        output retire_valid, retire_pc, retire_ir, rd_ready,
        input  rd_valid, rd_pc, rd_ir, rd_cycle
    );
endinterface

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port.
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = entry_w(XLEN_DEF, CNT_W_DEF)
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/trace_monitor.sv
// Retired-instruction tracer: circular timestamped capture, trigger freeze,
// oldest-first drain over a valid/ready port.
module trace_monitor
    import trace_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 32,
    parameter int PW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    trace_monitor_if.master  bus,
    input  logic             arm,
    input  logic             clear,
    input  logic             trig_pc_en,
    input  logic [XLEN-1:0]  trig_pc,
    input  logic             trig_ext,
    input  logic [PW-1:0]    post_count,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [PW-1:0]    fill
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = entry_w(XLEN, CNT_W);

    state_t           st_q;
    state_t           st_d;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_idx;
    logic [PW-1:0]    fill_q;
    logic [PW-1:0]    remain_q;
    logic [PW-1:0]    post_q;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] retire_q;
    logic             trig;
    logic             cap;
    logic             rdv;
    logic             pop;
    logic [EW-1:0]    wdata;
    logic [EW-1:0]    rdata;
    logic [XLEN-1:0]  r_pc;
    logic [31:0]      r_ir;
    logic [CNT_W-1:0] r_cyc;

    assign trig = bus.retire_valid
                & ((trig_pc_en & (bus.retire_pc == trig_pc)) | trig_ext);
    assign pop  = rdv & bus.rd_ready & ~clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        if (clear) begin
            st_d = ST_IDLE;
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    if (arm) st_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig) begin
                        st_d = (post_q == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (bus.retire_valid && remain_q == PW'(1)) begin
                        st_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (pop && fill_q == PW'(1)) st_d = ST_IDLE;
                end
                default: st_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cap = 1'b0;
        rdv = 1'b0;
        unique case (st_q)
            ST_ARMED, ST_POST: cap = bus.retire_valid & ~clear;
            ST_DONE:           rdv = (fill_q != '0);
            default:           ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q  <= '0;
            retire_q <= '0;
            wr_ptr   <= '0;
            fill_q   <= '0;
            remain_q <= '0;
            post_q   <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (bus.retire_valid) begin
                retire_q <= retire_q + CNT_W'(1);
            end
            if (clear) begin
                wr_ptr <= '0;
                fill_q <= '0;
            end else if (st_q == ST_IDLE && arm) begin
                wr_ptr <= '0;
                fill_q <= '0;
                post_q <= post_count;
            end else if (cap) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (fill_q != PW'(DEPTH)) begin
                    fill_q <= fill_q + PW'(1);
                end
            end else if (pop) begin
                fill_q <= fill_q - PW'(1);
            end
            if (st_q == ST_ARMED && trig) begin
                remain_q <= post_q;
            end else if (st_q == ST_POST && cap) begin
                remain_q <= remain_q - PW'(1);
            end
        end
    end

    // With a full buffer the low bits of fill are zero, so the oldest
    // entry sits exactly at wr_ptr.
    assign rd_idx = wr_ptr - fill_q[AW-1:0];
    assign wdata  = {bus.retire_pc, bus.retire_ir, cycle_q};

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clk   (clk),
        .we    (cap),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_idx),
        .rdata (rdata)
    );

    assign {r_pc, r_ir, r_cyc} = rdata;

    assign bus.rd_valid = rdv;
    assign bus.rd_pc    = rdv ? r_pc  : '0;
    assign bus.rd_ir    = rdv ? r_ir  : '0;
    assign bus.rd_cycle = rdv ? r_cyc : '0;

    assign state      = st_q;
    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;
    assign fill       = fill_q;
endmodule

// File: tb/tb_trace_monitor.sv
// Directed bench for trace_monitor: vector table plus multi-cycle sequences.
module tb_trace_monitor;
    import trace_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = 32;
    localparam int PW    = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             arm;
    logic             clear;
    logic             trig_pc_en;
    logic [XLEN-1:0]  trig_pc;
    logic             trig_ext;
    logic [PW-1:0]    post_count;
    logic [1:0]       state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic [PW-1:0]    fill;

    trace_monitor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    trace_monitor #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .PW    (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .arm        (arm),
        .clear      (clear),
        .trig_pc_en (trig_pc_en),
        .trig_pc    (trig_pc),
        .trig_ext   (trig_ext),
        .post_count (post_count),
        .state      (state),
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt),
        .fill       (fill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        int          cyc;
    } ent_t;

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic        arm;
        logic        clr;
        logic        ext;
        logic        cap;
        logic [1:0]  st;
        logic [4:0]  fl;
    } vec_t;

    ent_t sb[$];
    vec_t tv[12];
    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;
    int   nret = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) cyc++;
        #1;
    endtask

    task automatic drive(input logic rv, input logic [31:0] pc,
                         input logic cap);
        logic [31:0] ir;
        ir = pc ^ 32'h1357_9BDF;
        bus.retire_valid = rv;
        bus.retire_pc    = pc;
        bus.retire_ir    = ir;
        if (rv) nret++;
        if (cap) begin
            sb.push_back('{pc, ir, cyc});
            if (sb.size() > DEPTH) void'(sb.pop_front());
        end
        step();
        bus.retire_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        ent_t e;
        int   n;
        n = sb.size();
        chk({tag, " fill"}, fill, n);
        chk({tag, " state"}, state, 2'd3);
        for (int i = 0; i < n; i++) begin
            e = sb.pop_front();
            bus.rd_ready = 1'b1;
            chk($sformatf("%s[%0d] rd_valid", tag, i), bus.rd_valid, 1);
            chk($sformatf("%s[%0d] rd_pc", tag, i), bus.rd_pc, e.pc);
            chk($sformatf("%s[%0d] rd_ir", tag, i), bus.rd_ir, e.ir);
            chk($sformatf("%s[%0d] rd_cycle", tag, i), bus.rd_cycle, e.cyc);
            step();
        end
        bus.rd_ready = 1'b0;
        chk({tag, " end state"}, state, 2'd0);
        chk({tag, " end rd_valid"}, bus.rd_valid, 0);
        chk({tag, " end fill"}, fill, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{1, 32'h010, 0, 0, 0, 0, 2'd0, 5'd0};
        tv[1]  = '{1, 32'h014, 1, 0, 0, 0, 2'd1, 5'd0};
        tv[2]  = '{1, 32'h018, 0, 0, 0, 1, 2'd1, 5'd1};
        tv[3]  = '{0, 32'h000, 0, 0, 0, 0, 2'd1, 5'd1};
        tv[4]  = '{1, 32'h01C, 1, 1, 0, 0, 2'd0, 5'd0};
        tv[5]  = '{0, 32'h000, 1, 0, 0, 0, 2'd1, 5'd0};
        tv[6]  = '{1, 32'h100, 0, 0, 0, 1, 2'd1, 5'd1};
        tv[7]  = '{0, 32'h000, 0, 0, 1, 0, 2'd1, 5'd1};
        tv[8]  = '{1, 32'h104, 0, 0, 0, 1, 2'd1, 5'd2};
        tv[9]  = '{1, 32'h108, 0, 0, 1, 1, 2'd3, 5'd3};
        tv[10] = '{1, 32'h10C, 0, 0, 0, 0, 2'd3, 5'd3};
        tv[11] = '{0, 32'h000, 1, 0, 0, 0, 2'd3, 5'd3};

        bus.retire_valid = 1'b0;
        bus.retire_pc    = '0;
        bus.retire_ir    = '0;
        bus.rd_ready     = 1'b0;
        arm        = 1'b0;
        clear      = 1'b0;
        trig_pc_en = 1'b0;
        trig_pc    = '0;
        trig_ext   = 1'b0;
        post_count = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("por state", state, 0);
        chk("por fill", fill, 0);
        chk("por rd_valid", bus.rd_valid, 0);
        chk("por rd_pc", bus.rd_pc, 0);
        chk("por cycle_cnt", cycle_cnt, 0);
        chk("por retire_cnt", retire_cnt, 0);
        rst = 1'b1;
        step();
        chk("cycle_cnt tick", cycle_cnt, 1);

        // Reset asserted in the middle of POST
        post_count = 5'd5;
        arm = 1'b1;
        drive(0, 32'h0, 0);
        arm = 1'b0;
        trig_ext = 1'b1;
        drive(1, 32'h200, 0);
        trig_ext = 1'b0;
        drive(1, 32'h204, 0);
        chk("mid state", state, 2'd2);
        chk("mid fill", fill, 2);
        rst = 1'b0;
        cyc = 0;
        nret = 0;
        repeat (3) step();
        rst = 1'b1;
        chk("rst state", state, 0);
        chk("rst fill", fill, 0);
        chk("rst rd_valid", bus.rd_valid, 0);
        chk("rst cycle_cnt", cycle_cnt, 0);
        chk("rst retire_cnt", retire_cnt, 0);

        // Table: idle retire, arm-cycle retire, clear beating arm, ext trigger
        post_count = '0;
        foreach (tv[i]) begin
            arm      = tv[i].arm;
            clear    = tv[i].clr;
            trig_ext = tv[i].ext;
            if (tv[i].clr) sb.delete();
            drive(tv[i].rv, tv[i].pc, tv[i].cap);
            arm      = 1'b0;
            clear    = 1'b0;
            trig_ext = 1'b0;
            chk($sformatf("tv%0d state", i), state, tv[i].st);
            chk($sformatf("tv%0d fill", i), fill, tv[i].fl);
            chk($sformatf("tv%0d rd_valid", i), bus.rd_valid,
                (tv[i].st == 2'd3) && (tv[i].fl != 0));
        end
        chk("retire_cnt", retire_cnt, nret);
        chk("cycle_cnt", cycle_cnt, cyc);

        // Stalled consumer: the head entry must hold steady
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d rd_valid", i), bus.rd_valid, 1);
            chk($sformatf("stall%0d rd_pc", i), bus.rd_pc, sb[0].pc);
            chk($sformatf("stall%0d rd_cycle", i), bus.rd_cycle, sb[0].cyc);
            step();
        end
        drain("ext");

        // PC-match trigger with two post-trigger entries and wrap
        post_count = 5'd2;
        trig_pc    = 32'h40;
        trig_pc_en = 1'b1;
        arm = 1'b1;
        drive(0, 32'h0, 0);
        arm = 1'b0;
        chk("pc armed", state, 2'd1);
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'(i * 4), (i * 4) <= 32'h48);
            if (i == 16) chk("pc post", state, 2'd2);
            if (i == 18) chk("pc done", state, 2'd3);
        end
        trig_pc_en = 1'b0;
        drain("pc");

        // Post count beyond depth: trigger entry overwritten
        post_count = 5'd20;
        arm = 1'b1;
        drive(0, 32'h0, 0);
        arm = 1'b0;
        for (int i = 0; i < 26; i++) begin
            trig_ext = (i == 5);
            drive(1, 32'h1000 + 32'(i * 4), 1);
            trig_ext = 1'b0;
            if (i == 5)  chk("wrap trig", state, 2'd2);
            if (i == 24) chk("wrap post", state, 2'd2);
        end
        drain("wrap");
        chk("final retire_cnt", retire_cnt, nret);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
